// File: rtl/valu_seq.sv
// Multi-cycle vector ALU: accepts one operand bundle, processes the VLEN-bit register in
// DLEN-bit beats with masking and tail-undisturbed handling, then holds the result for writeback.
module valu_seq #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned DLEN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [2:0]                i_sew,
  input  logic [5:0]                i_ctrl,
  input  logic [$clog2(VLEN/8):0]   i_vl,
  input  logic                      i_vm,
  input  logic [VLEN/8-1:0]         i_mask,
  input  logic [VLEN-1:0]           i_dataa,
  input  logic [VLEN-1:0]           i_datab,
  input  logic [VLEN-1:0]           i_vd_old,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [VLEN-1:0]           o_result,
  output logic                      o_err
);

  localparam int unsigned BEATS = VLEN / DLEN;
  localparam int unsigned NB    = VLEN / 8;
  localparam int unsigned VLW   = $clog2(NB) + 1;
  localparam int unsigned BW    = $clog2(BEATS + 1);

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpSlt  = 6'b000010;
  localparam logic [5:0] OpSltu = 6'b000011;
  localparam logic [5:0] OpAnd  = 6'b000100;
  localparam logic [5:0] OpOr   = 6'b000101;
  localparam logic [5:0] OpXor  = 6'b000110;
  localparam logic [5:0] OpSll  = 6'b011000;
  localparam logic [5:0] OpSrl  = 6'b011001;
  localparam logic [5:0] OpSra  = 6'b011010;
  localparam logic [5:0] OpMinu = 6'b001000;
  localparam logic [5:0] OpMin  = 6'b001001;
  localparam logic [5:0] OpMaxu = 6'b001010;
  localparam logic [5:0] OpMax  = 6'b001011;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [2:0]         sew_q, sew_d;
  logic [5:0]         ctrl_q, ctrl_d;
  logic [VLW-1:0]     vl_q, vl_d;
  logic               vm_q, vm_d;
  logic [NB-1:0]      mask_q, mask_d;
  logic [VLEN-1:0]    a_q, a_d, b_q, b_d, old_q, old_d;
  logic [VLEN-1:0]    result_q, result_d;
  logic               err_q, err_d;

  // Operands arrive zero-extended; sz selects element width for sign and shift-amount handling.
  function automatic logic [63:0] alu_elem(input logic [5:0] op, input logic [1:0] sz,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] sa, sb, r;
    logic [5:0]  sh;
    case (sz)
      2'd0: begin sa = {{56{a[7]}}, a[7:0]};   sb = {{56{b[7]}}, b[7:0]};   sh = {3'b0, b[2:0]}; end
      2'd1: begin sa = {{48{a[15]}}, a[15:0]}; sb = {{48{b[15]}}, b[15:0]}; sh = {2'b0, b[3:0]}; end
      2'd2: begin sa = {{32{a[31]}}, a[31:0]}; sb = {{32{b[31]}}, b[31:0]}; sh = {1'b0, b[4:0]}; end
      default: begin sa = a; sb = b; sh = b[5:0]; end
    endcase
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpSlt:   r = {63'b0, $signed(sa) < $signed(sb)};
      OpSltu:  r = {63'b0, a < b};
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpSll:   r = a << sh;
      OpSrl:   r = a >> sh;
      OpSra:   r = $signed(sa) >>> sh;
      OpMinu:  r = (a < b) ? a : b;
      OpMin:   r = ($signed(sa) < $signed(sb)) ? a : b;
      OpMaxu:  r = (a < b) ? b : a;
      OpMax:   r = ($signed(sa) < $signed(sb)) ? b : a;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [DLEN-1:0]       a_beat, b_beat, old_beat, beat_res;
  logic [3:0][DLEN-1:0]  chunk;

  assign a_beat   = DLEN'(a_q >> (beat_q * DLEN));
  assign b_beat   = DLEN'(b_q >> (beat_q * DLEN));
  assign old_beat = DLEN'(old_q >> (beat_q * DLEN));

  // One candidate beat result per legal SEW; the registered SEW picks one below.
  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int unsigned W     = 8 << s;
    localparam int unsigned NE    = DLEN / W;
    localparam int unsigned VLMAX = VLEN / W;
    logic [VLW-1:0] base;
    logic [NE-1:0]  mask_s;
    assign base   = VLW'(beat_q) * VLW'(NE);
    assign mask_s = NE'(mask_q >> base);
    for (genvar e = 0; e < NE; e++) begin : g_elem
      logic [VLW-1:0] idx;
      logic           act;
      assign idx = base + VLW'(e);
      assign act = (idx < vl_q) && (idx < VLW'(VLMAX)) && (vm_q || mask_s[e]);
      assign chunk[s][e*W +: W] = act ?
          W'(alu_elem(ctrl_q, 2'(s), 64'(a_beat[e*W +: W]), 64'(b_beat[e*W +: W]))) :
          old_beat[e*W +: W];
    end
  end

  assign beat_res = sew_q[2] ? old_beat : chunk[sew_q[1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q   <= '0;
      sew_q    <= '0;
      ctrl_q   <= '0;
      vl_q     <= '0;
      vm_q     <= 1'b0;
      mask_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      old_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      sew_q    <= sew_d;
      ctrl_q   <= ctrl_d;
      vl_q     <= vl_d;
      vm_q     <= vm_d;
      mask_q   <= mask_d;
      a_q      <= a_d;
      b_q      <= b_d;
      old_q    <= old_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_valid) state_d = StRun;
      StRun:   if (beat_q == BW'(BEATS)) state_d = StDone;
      StDone:  if (i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beats 0..BEATS-1 fill the result; the extra count at BEATS is a settle cycle that
  // latches the error flag and places o_valid BEATS+1 cycles after accept.
  always_comb begin
    beat_d   = beat_q;
    sew_d    = sew_q;
    ctrl_d   = ctrl_q;
    vl_d     = vl_q;
    vm_d     = vm_q;
    mask_d   = mask_q;
    a_d      = a_q;
    b_d      = b_q;
    old_d    = old_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          beat_d = '0;
          sew_d  = i_sew;
          ctrl_d = i_ctrl;
          vl_d   = i_vl;
          vm_d   = i_vm;
          mask_d = i_mask;
          a_d    = i_dataa;
          b_d    = i_datab;
          old_d  = i_vd_old;
          err_d  = 1'b0;
        end
      end
      StRun: begin
        if (beat_q == BW'(BEATS)) begin
          err_d = sew_q[2];
        end else begin
          result_d = (result_q & ~(VLEN'({DLEN{1'b1}}) << (beat_q * DLEN))) |
                     (VLEN'(beat_res) << (beat_q * DLEN));
          beat_d   = beat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ready  = (state_q == StIdle);
    o_valid  = (state_q == StDone);
    o_result = result_q;
    o_err    = err_q;
  end

endmodule

// File: tb/tb_valu_seq.sv
// Directed, table-driven bench for valu_seq at VLEN=128, DLEN=64 plus backpressure and reset runs.
module tb_valu_seq;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, SLT = 6'b000010, SLTU = 6'b000011;
  localparam logic [5:0] AND = 6'b000100, OR = 6'b000101, XOR = 6'b000110;
  localparam logic [5:0] SLL = 6'b011000, SRL = 6'b011001, SRA = 6'b011010;
  localparam logic [5:0] MINU = 6'b001000, MIN = 6'b001001, MAXU = 6'b001010, MAX = 6'b001011;

  logic         clk, rst, i_valid, o_ready, i_vm, o_valid, i_ready, o_err;
  logic [2:0]   i_sew;
  logic [5:0]   i_ctrl;
  logic [4:0]   i_vl;
  logic [15:0]  i_mask;
  logic [127:0] i_dataa, i_datab, i_vd_old, o_result;

  valu_seq #(.VLEN(128), .DLEN(64)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_sew(i_sew),
    .i_ctrl(i_ctrl), .i_vl(i_vl), .i_vm(i_vm), .i_mask(i_mask), .i_dataa(i_dataa),
    .i_datab(i_datab), .i_vd_old(i_vd_old), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   sew;
    logic [5:0]   ctrl;
    logic [4:0]   vl;
    logic         vm;
    logic [15:0]  mask;
    logic [127:0] a, b, old, exp;
    logic         exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vt[$];

  function automatic vec_t mk(string nm, logic [2:0] sew, logic [5:0] ctrl, logic [4:0] vl,
                              logic vm, logic [15:0] mask, logic [127:0] a, logic [127:0] b,
                              logic [127:0] old, logic [127:0] exp, logic exp_err);
    vec_t v;
    v.name = nm; v.sew = sew; v.ctrl = ctrl; v.vl = vl; v.vm = vm; v.mask = mask;
    v.a = a; v.b = b; v.old = old; v.exp = exp; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_sew = v.sew; i_ctrl = v.ctrl; i_vl = v.vl; i_vm = v.vm; i_mask = v.mask;
    i_dataa = v.a; i_datab = v.b; i_vd_old = v.old;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    wait_valid(lat);
    chk({v.name, " latency"}, 128'(lat), 128'd3);
    chk({v.name, " result"}, o_result, v.exp);
    chk({v.name, " err"}, 128'(o_err), 128'(v.exp_err));
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v1, v2, junk;
    int lat;

    vt.push_back(mk("add8", 3'd0, ADD, 5'd16, 1'b1, 16'h0, {16{8'hFF}}, {16{8'h01}},
                    {16{8'h55}}, 128'h0, 1'b0));
    vt.push_back(mk("sra32", 3'd2, SRA, 5'd4, 1'b1, 16'h0, {4{32'h80000000}}, {4{32'h21}},
                    128'h0, {4{32'hC0000000}}, 1'b0));
    vt.push_back(mk("sll32", 3'd2, SLL, 5'd4, 1'b1, 16'h0, {4{32'h1}}, {4{32'h21}},
                    128'h0, {4{32'h2}}, 1'b0));
    vt.push_back(mk("sub16_mask", 3'd1, SUB, 5'd5, 1'b0, 16'h0015, {8{16'h0005}},
                    {8{16'h0003}}, {8{16'hAAAA}},
                    128'hAAAA_AAAA_AAAA_0002_AAAA_0002_AAAA_0002, 1'b0));
    vt.push_back(mk("slt64", 3'd3, SLT, 5'd2, 1'b1, 16'h0, {128{1'b1}}, 128'h0,
                    {16{8'h55}}, {2{64'h1}}, 1'b0));
    vt.push_back(mk("minu64", 3'd3, MINU, 5'd2, 1'b1, 16'h0, {128{1'b1}}, 128'h0,
                    {16{8'h55}}, 128'h0, 1'b0));
    vt.push_back(mk("max64", 3'd3, MAX, 5'd2, 1'b1, 16'h0, {128{1'b1}}, 128'h0,
                    {16{8'h55}}, 128'h0, 1'b0));
    vt.push_back(mk("minu64_vl20", 3'd3, MINU, 5'd20, 1'b1, 16'h0, {128{1'b1}}, 128'h0,
                    {16{8'h55}}, 128'h0, 1'b0));
    vt.push_back(mk("sew5", 3'd5, ADD, 5'd16, 1'b1, 16'h0, {128{1'b1}}, {128{1'b1}},
                    128'h0123456789ABCDEF_FEDCBA9876543210,
                    128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1));
    vt.push_back(mk("min8", 3'd0, MIN, 5'd16, 1'b1, 16'h0, {16{8'h80}}, {16{8'h7F}},
                    128'h0, {16{8'h80}}, 1'b0));
    vt.push_back(mk("max8", 3'd0, MAX, 5'd16, 1'b1, 16'h0, {16{8'h80}}, {16{8'h7F}},
                    128'h0, {16{8'h7F}}, 1'b0));
    vt.push_back(mk("maxu8", 3'd0, MAXU, 5'd16, 1'b1, 16'h0, {16{8'h80}}, {16{8'h7F}},
                    128'h0, {16{8'h80}}, 1'b0));
    vt.push_back(mk("slt8", 3'd0, SLT, 5'd16, 1'b1, 16'h0, {16{8'h80}}, {16{8'h01}},
                    128'h0, {16{8'h01}}, 1'b0));
    vt.push_back(mk("sltu8", 3'd0, SLTU, 5'd16, 1'b1, 16'h0, {16{8'h80}}, {16{8'h01}},
                    {128{1'b1}}, 128'h0, 1'b0));
    vt.push_back(mk("srl16", 3'd1, SRL, 5'd8, 1'b1, 16'h0, {8{16'h8000}}, {8{16'h0013}},
                    128'h0, {8{16'h1000}}, 1'b0));
    vt.push_back(mk("undef_op", 3'd2, 6'h3F, 5'd4, 1'b1, 16'h0,
                    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, {128{1'b1}}, 128'h0,
                    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0));
    vt.push_back(mk("vl0", 3'd0, ADD, 5'd0, 1'b1, 16'h0, {16{8'h11}}, {16{8'h22}},
                    128'hFEDCBA98_76543210_01234567_89ABCDEF,
                    128'hFEDCBA98_76543210_01234567_89ABCDEF, 1'b0));
    vt.push_back(mk("and16", 3'd1, AND, 5'd8, 1'b1, 16'h0, {8{16'hF0F0}}, {8{16'hFF00}},
                    128'h0, {8{16'hF000}}, 1'b0));
    vt.push_back(mk("xor8_mask", 3'd0, XOR, 5'd16, 1'b0, 16'h00FF, {16{8'hFF}},
                    {16{8'h0F}}, 128'h0, {64'h0, {8{8'hF0}}}, 1'b0));
    vt.push_back(mk("sub32_vl3", 3'd2, SUB, 5'd3, 1'b1, 16'h0, 128'h0, {4{32'h1}}, 128'h0,
                    128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0));
    vt.push_back(mk("or32", 3'd2, OR, 5'd4, 1'b1, 16'h0, {4{32'h0F0F0000}},
                    {4{32'h0000F0F0}}, 128'h0, {4{32'h0F0FF0F0}}, 1'b0));
    vt.push_back(mk("sra64", 3'd3, SRA, 5'd2, 1'b1, 16'h0, {2{64'h8000000000000000}},
                    {2{64'h41}}, 128'h0, {2{64'hC000000000000000}}, 1'b0));

    v1 = mk("bp_first", 3'd0, ADD, 5'd16, 1'b1, 16'h0, {16{8'h01}}, {16{8'h02}}, 128'h0,
            {16{8'h03}}, 1'b0);
    v2 = mk("bp_second", 3'd1, XOR, 5'd8, 1'b1, 16'h0, {8{16'h1234}}, {8{16'hFFFF}},
            128'h0, {8{16'hEDCB}}, 1'b0);
    junk = mk("junk", 3'd5, SUB, 5'd1, 1'b0, 16'h0, 128'h0, {128{1'b1}}, {128{1'b1}},
              128'h0, 1'b0);

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    drive(junk);
    repeat (2) @(negedge clk);
    chk("reset o_ready", 128'(o_ready), 128'd1);
    chk("reset o_valid", 128'(o_valid), 128'd0);
    chk("reset o_err", 128'(o_err), 128'd0);
    chk("reset o_result", o_result, 128'h0);
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Backpressure: result held while i_ready low; a held i_valid is taken only after handshake.
    @(negedge clk);
    drive(v1);
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    wait_valid(lat);
    chk("bp latency", 128'(lat), 128'd3);
    drive(v2);
    i_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp hold o_valid", 128'(o_valid), 128'd1);
      chk("bp hold o_ready", 128'(o_ready), 128'd0);
      chk("bp hold o_result", o_result, v1.exp);
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    chk("bp after hs o_valid", 128'(o_valid), 128'd0);
    chk("bp after hs o_ready", 128'(o_ready), 128'd1);
    @(posedge clk);
    #1;
    chk("bp second accepted", 128'(o_ready), 128'd0);
    i_valid = 1'b0;
    drive(junk);
    wait_valid(lat);
    chk("bp second latency", 128'(lat), 128'd3);
    chk("bp second result", o_result, v2.exp);
    chk("bp second err", 128'(o_err), 128'd0);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;

    // Reset during RUN beat 0 discards the instruction immediately.
    @(negedge clk);
    drive(v1);
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrun rst o_valid", 128'(o_valid), 128'd0);
    chk("midrun rst o_ready", 128'(o_ready), 128'd1);
    chk("midrun rst o_result", o_result, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(v2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
